fetch_stage: RTL and testbench

//  Instruction-fetch front end for the pipelined core.
//  - Owns the PC and issues word requests to instruction memory; memory latency is variable, responses return in order.
//  - Buffers returned instructions and hands {instr, pc} to the decode stage over a valid/ready handshake.
//  - Supports redirect (branch/jump/jr) with flush of buffered and in-flight fetches.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared core types: instruction/address words, fetch buffer entry and reset PC.
// Imported by the fetch front end and its buffering sub-module.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic addr_t word_align(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's external buses: redirect input, instruction memory
// request/response channel and the decode-side valid/ready handshake.
interface fetch_stage_if;
  import mips_pkg::*;

  logic   redirect_valid;
  addr_t  redirect_pc;

  logic   imem_req_valid;
  addr_t  imem_req_addr;
  logic   imem_req_ready;
  logic   imem_rsp_valid;
  instr_t imem_rsp_data;

  logic   id_valid;
  instr_t id_instr;
  addr_t  id_pc;
  logic   id_ready;

  // master: the fetch stage itself; slave: memory + decode + redirect source.
  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_ready,
    output imem_req_valid, imem_req_addr,
    output id_valid, id_instr, id_pc
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_ready,
    input  imem_req_valid, imem_req_addr,
    input  id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of DEPTH entries of type T with flush, occupancy count
// and same-cycle push/pop. Head output reads as zero while empty.
module fetch_fifo import mips_pkg::*; #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  output T                             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !flush && (cnt_q == CNT_W'(DEPTH)) && !pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, in-order imem requests, response buffer, redirect flush.
// Define FETCH_TRACE_EN to print each decode handshake and redirect during simulation.
module fetch_stage import mips_pkg::*; #(
  parameter addr_t       RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 2;

  addr_t            pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] tag_count;
  logic [SUM_W-1:0] occupancy;
  logic             req_fire;
  logic             rsp_push;
  logic             id_fire;
  fetch_entry_t     buf_din;
  fetch_entry_t     buf_dout;
  addr_t            tag_dout;

  // Every request reserves a buffer slot up front, so responses never need backpressure.
  always_comb begin
    occupancy          = SUM_W'(out_q) + SUM_W'(buf_count) + SUM_W'(drop_q);
    bus.imem_req_valid = !reset && !bus.redirect_valid && (occupancy < SUM_W'(DEPTH));
    bus.imem_req_addr  = pc_q;
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    rsp_push           = bus.imem_rsp_valid && !bus.redirect_valid &&
                         (drop_q == '0) && (out_q != '0);
    buf_din            = '{instr: bus.imem_rsp_data, pc: tag_dout};
  end

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (bus.redirect_valid) begin
      pc_d   = word_align(bus.redirect_pc);
      out_d  = '0;
      // Everything still in flight, including a response landing now, gets discarded.
      drop_d = drop_q + out_q;
      if (bus.imem_rsp_valid && (drop_d != '0)) drop_d = drop_d - CNT_W'(1);
    end else begin
      if (req_fire) begin
        pc_d  = pc_q + 32'd4;
        out_d = out_d + CNT_W'(1);
      end
      if (rsp_push) out_d = out_d - CNT_W'(1);
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(addr_t)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (req_fire),
    .din   (pc_q),
    .pop   (rsp_push),
    .dout  (tag_dout),
    .count (tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_rsp_buf (
    .clk   (clk),
    .reset (reset),
    .flush (bus.redirect_valid),
    .push  (rsp_push),
    .din   (buf_din),
    .pop   (id_fire),
    .dout  (buf_dout),
    .count (buf_count)
  );

  always_comb begin
    bus.id_valid = (buf_count != '0);
    bus.id_instr = buf_dout.instr;
    bus.id_pc    = buf_dout.pc;
    id_fire      = bus.id_valid && bus.id_ready;
  end

  a_tags_match: assert property (@(posedge clk) disable iff (reset) tag_count == out_q);
  a_occupancy:  assert property (@(posedge clk) disable iff (reset) occupancy <= SUM_W'(DEPTH));

`ifdef FETCH_TRACE_EN
  always @(posedge clk) begin
    if (!reset && id_fire)
      $display("%d@%h: fetch %h", $time, bus.id_pc, bus.id_instr);
    if (!reset && bus.redirect_valid)
      $display("%d@%h: redirect", $time, bus.redirect_pc);
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order variable-latency memory and a
// transaction-level model (request address stream, expected decode queue, epochs).
`timescale 1ns/1ps
module tb_fetch_stage;
  import mips_pkg::*;

  localparam int    DEPTH  = 2;
  localparam addr_t RST_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    addr_t addr;
    int    due;
    int    epoch;
    bit    stray;
  } mreq_t;

  mreq_t memq[$];
  addr_t expq[$];
  int    checks = 0;
  int    failures = 0;
  int    cycle = 0;
  int    epoch = 0;
  int    delivered = 0;
  addr_t last_pc = '0;
  addr_t exp_req_addr = RST_PC;

  int    p_redirect = 0;
  int    p_idready = 100;
  int    p_reqready = 100;
  int    lat_min = 1;
  int    lat_max = 1;
  bit    force_redirect = 0;
  addr_t force_pc = '0;
  bit    rst_now = 0;

  function automatic instr_t mem_word(input addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic run_cycle();
    bit    has_stray;
    bit    rsp;
    bit    redir;
    bit    exp_req_valid;
    bit    fire_req;
    bit    fire_id;
    int    in_flight;
    mreq_t head;
    addr_t rpc;

    @(negedge clk);
    cycle++;
    if (rst_now) foreach (memq[i]) memq[i].stray = 1'b1;
    has_stray = 1'b0;
    foreach (memq[i]) if (memq[i].stray) has_stray = 1'b1;

    redir = force_redirect || (int'($urandom_range(99)) < p_redirect);
    if (force_redirect) rpc = force_pc;
    else if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else rpc = 32'h0000_3000 + ($urandom & 32'h3FF);

    in_flight = memq.size();
    rsp = (memq.size() != 0) && (memq[0].due <= cycle);
    head = '{addr: '0, due: 0, epoch: -1, stray: 1'b1};
    if (rsp) head = memq.pop_front();

    reset                  = rst_now;
    bus.redirect_valid     = redir && !rst_now;
    bus.redirect_pc        = rpc;
    bus.id_ready           = (int'($urandom_range(99)) < p_idready);
    bus.imem_req_ready     = !has_stray && (int'($urandom_range(99)) < p_reqready);
    bus.imem_rsp_valid     = rsp;
    bus.imem_rsp_data      = rsp ? mem_word(head.addr) : $urandom;
    exp_req_valid          = !bus.redirect_valid && (in_flight + expq.size() < DEPTH);
    #1;

    if (rst_now) begin
      check_eq("rst_req_valid", bus.imem_req_valid, 0);
      check_eq("rst_id_valid", bus.id_valid, 0);
      check_eq("rst_id_instr", bus.id_instr, 0);
      check_eq("rst_id_pc", bus.id_pc, 0);
      expq.delete();
      epoch++;
      exp_req_addr = RST_PC;
      $display("cycle %0d reset", cycle);
      return;
    end

    check_eq("id_valid", bus.id_valid, expq.size() != 0);
    if (expq.size() != 0) begin
      check_eq("id_pc", bus.id_pc, expq[0]);
      check_eq("id_instr", bus.id_instr, mem_word(expq[0]));
    end
    if (!has_stray) check_eq("req_valid", bus.imem_req_valid, exp_req_valid);
    if (bus.imem_req_valid) check_eq("req_addr", bus.imem_req_addr, exp_req_addr);

    fire_req = bus.imem_req_valid && bus.imem_req_ready;
    fire_id  = bus.id_valid && bus.id_ready;
    if (fire_id && expq.size() != 0) begin
      delivered++;
      last_pc = bus.id_pc;
      $display("cycle %0d deliver pc=%h instr=%h", cycle, bus.id_pc, bus.id_instr);
      void'(expq.pop_front());
    end
    if (fire_req) begin
      memq.push_back('{addr: exp_req_addr,
                       due: cycle + int'($urandom_range(lat_max, lat_min)),
                       epoch: epoch, stray: 1'b0});
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (rsp && !head.stray && head.epoch == epoch && !bus.redirect_valid)
      expq.push_back(head.addr);
    if (bus.redirect_valid) begin
      expq.delete();
      epoch++;
      exp_req_addr = word_align(rpc);
      $display("cycle %0d redirect pc=%h", cycle, rpc);
    end
  endtask

  task automatic expect_first(input string tag, input addr_t pc);
    int d0;
    int n;
    d0 = delivered;
    n = 0;
    while (delivered == d0 && n < 60) begin
      run_cycle();
      n++;
    end
    check_eq({tag, "_seen"}, delivered != d0, 1);
    check_eq(tag, last_pc, pc);
  endtask

  initial begin
    int d0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;

    rst_now = 1;
    repeat (2) run_cycle();
    rst_now = 0;

    // Streaming with single-cycle memory
    expect_first("t1_first_pc", 32'h0000_3000);
    expect_first("t1_second_pc", 32'h0000_3004);
    repeat (30) run_cycle();

    // Decode stall and release
    p_idready = 0;
    repeat (10) run_cycle();
    p_idready = 100;
    repeat (10) run_cycle();

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    repeat (3) run_cycle();
    force_redirect = 1; force_pc = 32'h0000_3400;
    run_cycle();
    force_redirect = 0;
    lat_min = 1; lat_max = 1;
    expect_first("t3_redirect_pc", 32'h0000_3400);

    // Unaligned target and back-to-back redirects
    force_redirect = 1; force_pc = 32'h0000_3403;
    run_cycle();
    force_redirect = 0;
    expect_first("t4_aligned_pc", 32'h0000_3400);
    force_redirect = 1; force_pc = 32'h0000_3100;
    run_cycle();
    force_pc = 32'h0000_3200;
    run_cycle();
    force_redirect = 0;
    expect_first("t4_b2b_pc", 32'h0000_3200);

    // Memory not ready
    p_reqready = 0;
    repeat (5) run_cycle();
    p_reqready = 100;
    repeat (5) run_cycle();

    // Reset with outstanding requests; late responses must be ignored
    lat_min = 3; lat_max = 3;
    repeat (4) run_cycle();
    rst_now = 1;
    run_cycle();
    rst_now = 0;
    lat_min = 1; lat_max = 1;
    expect_first("t6_post_reset_pc", 32'h0000_3000);

    // Randomized traffic
    for (int blk = 0; blk < 30; blk++) begin
      p_redirect = int'($urandom_range(10));
      p_idready  = int'($urandom_range(100, 20));
      p_reqready = int'($urandom_range(100, 20));
      lat_min    = 1;
      lat_max    = int'($urandom_range(5, 1));
      for (int c = 0; c < 100; c++) begin
        rst_now = ($urandom_range(199) == 0);
        run_cycle();
      end
      rst_now = 0;
    end

    // Drain: the stream must keep flowing once the environment is quiet
    p_redirect = 0; p_idready = 100; p_reqready = 100; lat_min = 1; lat_max = 1;
    d0 = delivered;
    repeat (40) run_cycle();
    check_eq("drain_progress", delivered > d0 + 5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
